// File: rtl/synth_pkg.sv
// Shared types for the synth gate path.
// State encoding and default widths.
package synth_pkg;

  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

endpackage

// File: rtl/tick_stretcher_if.sv
// Tick-in / gate-out bundle for tick_stretcher.
// master drives the tick side, slave is the stretcher.
interface tick_stretcher_if #(
  parameter int CNT_W = 24
);

  logic             tick;
  logic [CNT_W-1:0] len;
  logic             retrig_en;
  logic             gate;
  logic             busy;
  logic             done;

  modport master (
    output tick, len, retrig_en,
    input  gate, busy, done
  );

  modport slave (
    input  tick, len, retrig_en,
    output gate, busy, done
  );

endinterface

// File: rtl/load_down_counter.sv
// Loadable down counter with zero flag.
// Load wins over decrement; never wraps below zero.
module load_down_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: load, else saturating decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tick_stretcher.sv
// Stretches one-cycle ticks into a gate level.
// Optional retrigger, fixed low gap after each gate.
module tick_stretcher
  import synth_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  tick_stretcher_if.slave io
);

  localparam logic [CNT_W-1:0] GAP_LOAD =
    CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  state_e           state_q;
  state_e           state_d;
  logic             done_q;
  logic             done_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             dec;
  logic             zero;
  logic [CNT_W-1:0] hold_val;

  // len of 0 behaves as 1, so reload value is max(len,1)-1
  assign hold_val = (io.len == '0) ? '0 : io.len - CNT_W'(1);

  // next state, counter control and done pulse
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_val = hold_val;
    dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.tick) begin
          state_d = ST_HOLD;
          load    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (io.tick && io.retrig_en) begin
          load = 1'b1;
        end else if (zero) begin
          done_d = 1'b1;
          if (GAP_LEN > 0) begin
            state_d  = ST_GAP;
            load     = 1'b1;
            load_val = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (zero) begin
          state_d = ST_IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and done flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  load_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  assign io.gate = (state_q == ST_HOLD);
  assign io.busy = (state_q != ST_IDLE);
  assign io.done = done_q;

endmodule

// File: tb/tb_tick_stretcher.sv
// Directed bench for tick_stretcher.
// Per-cycle vector table plus reset corner case.
module tb_tick_stretcher;

  logic clk;
  logic rst;

  tick_stretcher_if #(.CNT_W(24)) io ();

  tick_stretcher #(
    .CNT_W   (24),
    .GAP_LEN (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic [23:0] len;
    logic        rt;
    logic        g;
    logic        b;
    logic        d;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  task automatic add(input logic t, input int l, input logic r,
                     input logic g, input logic b, input logic d);
    vec_t v;
    v.tick = t;
    v.len  = 24'(l);
    v.rt   = r;
    v.g    = g;
    v.b    = b;
    v.d    = d;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic g,
                     input logic b, input logic d);
    total++;
    if (io.gate !== g || io.busy !== b || io.done !== d) begin
      bad++;
      $display("FAIL %s got g/b/d=%b%b%b want %b%b%b",
               nm, io.gate, io.busy, io.done, g, b, d);
    end
  endtask

  task automatic step(input logic t, input int l, input logic r);
    io.tick      = t;
    io.len       = 24'(l);
    io.retrig_en = r;
    @(posedge clk);
    #1;
  endtask

  // tail after a gate falls: done cycle, 3 more gap cycles, idle
  task automatic add_tail(input logic t);
    add(t, 5, 0, 0, 1, 1);
    add(t, 5, 0, 0, 1, 0);
    add(t, 5, 0, 0, 1, 0);
    add(t, 5, 0, 0, 1, 0);
    add(0, 5, 0, 0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    io.tick      = 1'b0;
    io.len       = '0;
    io.retrig_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 0, 0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // single len=5 gate, len changes mid-gate are ignored
    add(0, 5, 0, 0, 0, 0);
    add(1, 5, 0, 1, 1, 0);
    add(0, 9, 0, 1, 1, 0);
    add(0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    add(0, 5, 0, 1, 1, 0);
    add_tail(0);

    // len=0 acts as 1
    add(1, 0, 0, 1, 1, 0);
    add_tail(0);

    // retrigger in gate cycle 3 -> 8 cycles
    add(1, 5, 1, 1, 1, 0);
    add(0, 5, 1, 1, 1, 0);
    add(0, 5, 1, 1, 1, 0);
    add(1, 5, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 5, 1, 1, 1, 0);
    add_tail(0);

    // retrig off: tick ignored, gap ticks dropped, first idle tick taken
    add(1, 5, 0, 1, 1, 0);
    add(0, 5, 0, 1, 1, 0);
    add(0, 5, 0, 1, 1, 0);
    add(1, 5, 0, 1, 1, 0);
    add(0, 5, 0, 1, 1, 0);
    add(1, 5, 0, 0, 1, 1);
    add(1, 5, 0, 0, 1, 0);
    add(1, 5, 0, 0, 1, 0);
    add(1, 5, 0, 0, 1, 0);
    add(1, 5, 0, 0, 0, 0);
    add(1, 5, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 5, 0, 1, 1, 0);
    add_tail(0);

    // retrigger exactly at expiry -> 10 cycles, no early done
    add(1, 5, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 5, 1, 1, 1, 0);
    add(1, 5, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 5, 1, 1, 1, 0);
    add_tail(0);

    foreach (vq[i]) begin
      step(vq[i].tick, int'(vq[i].len), vq[i].rt);
      chk($sformatf("vec%0d", i), vq[i].g, vq[i].b, vq[i].d);
    end

    // async reset in gate cycle 2 of a len=100 gate
    step(1, 100, 0);
    chk("rst_pre1", 1, 1, 0);
    step(0, 100, 0);
    chk("rst_pre2", 1, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_hold", 0, 0, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel", 0, 0, 0);
    step(1, 3, 0);
    chk("post_g1", 1, 1, 0);
    step(0, 3, 0);
    chk("post_g2", 1, 1, 0);
    step(0, 3, 0);
    chk("post_g3", 1, 1, 0);
    step(0, 3, 0);
    chk("post_done", 0, 1, 1);
    repeat (3) begin
      step(0, 3, 0);
      chk("post_gap", 0, 1, 0);
    end
    step(0, 3, 0);
    chk("post_idle", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
